display_scroller: RTL and testbench
===================================

// Module: display_scroller
// PURPOSE
//   Scrolls a loaded hex message right-to-left across NDIGITS active-low seven-segment digits.
//   Sits directly downstream of the display clock-enable divider: each scroll step is one
//   `en` strobe from that divider (nominal 5 Hz). Feeds the board HEX pins.
// PARAMETERS
//   DEPTH    16  max message length in nibbles (width of load_len = $clog2(DEPTH+1))
//   NDIGITS   4  number of seven-segment digits driven
// PORTS
//   clk        in   1              system clock (50 MHz); single clock domain
//   reset      in   1              synchronous, active-high reset
//   en         in   1              scroll tick from clock-enable divider; level or 1-cycle pulse
//   load_valid in   1              message offer
//   load_ready out  1              block can accept a message
//   load_data  in   4*DEPTH        nibble k = load_data[4k+3:4k]; nibble 0 is shown first
//   load_len   in   $clog2(DEPTH+1) nibbles in message; values >DEPTH clamp to DEPTH
//   abort      in   1              stop scrolling immediately
//   busy       out  1              high while SCROLL
//   done       out  1              1-cycle pulse when scroll completes
//   hex_out    out  7*NDIGITS      digit d at [7d+6:7d], d=0 rightmost; active-low gfedcba
// BEHAVIOUR
//   - Reset: state=IDLE; load_ready=1, busy=0, done=0; all digits blank (7'h7F);
//     tick edge detector cleared (en high during reset does not produce a tick afterwards).
//   - Tick = rising edge of en (registered en_d; tick = en & ~en_d). Level-held en counts once.
//   - Display held as NDIGITS-entry shift register of {valid,nibble}; invalid entry -> 7'h7F.
//     Encoding 0-F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
//   - IDLE: load_ready=1. Accept when load_valid & load_ready: capture data and clamped length
//     into internal buffer, idx<=0, step count<=0, go SCROLL. Display keeps old contents until first tick.
//     load_len==0: accepted, no SCROLL; done pulses the cycle after accept; stay IDLE.
//   - SCROLL: load_ready=0, busy=1. On each tick: shift digits left (digit d <= digit d-1,
//     digit NDIGITS-1 discarded); digit 0 <= nibble[idx] if idx<len, else blank; idx++.
//     After len+NDIGITS ticks (display fully blank): done=1 for one cycle, go IDLE.
//   - Tick in the same cycle as accept is ignored; first shift occurs on next tick.
//   - load_valid while SCROLL is ignored (not captured, no back-pressure side effects).
//   - abort (any state): next cycle IDLE, all digits blank, no done pulse; abort beats tick
//     and load in the same cycle. Reset beats abort.
//   - hex_out, busy, load_ready, done all registered; hex_out updates 1 cycle after tick.
//   - idx and step counter sized to hold DEPTH+NDIGITS without wrap.
// CONFIGURATION
//   DISPLAY_SCROLL_LOOP_EN defined: after nibble len-1, one blank digit is inserted, then idx
//     wraps to 0 and the message repeats indefinitely; done never pulses; exit only via abort
//     or reset; load_ready stays 0 while looping.
//   Not defined: single pass as above, ending in done pulse and IDLE.
// TESTING
//   1. Reset with en held high, release, keep en high 10 cycles -> no shift, hex_out all 7F,
//      load_ready=1.
//   2. Load len=2, data nibbles {0:A,1:5}; 6 ticks -> digit0 sequence 08,12,7F,7F,...;
//      after tick 2 hex_out = {7F,7F,08,12}; done pulse 1 cycle after tick 6.
//   3. Load len=0 -> done pulses next cycle, busy never rises, display unchanged.
//   4. Load while busy (load_valid held 3 cycles) -> ignored, original message completes.
//   5. abort after tick 3 of len=8 message -> next cycle all 7F, IDLE, no done.
//   6. DISPLAY_SCROLL_LOOP_EN, len=1 data=F -> digit0 sequence 0E,7F,0E,7F,... for 10 ticks;
//      done stays 0.

Source files
------------

// File: rtl/display_scroller.sv
// Right-to-left hex message scroller for NDIGITS active-low seven-segment digits.
// Define DISPLAY_SCROLL_LOOP_EN to repeat the message (with one blank gap) until abort/reset.
module display_scroller #(
   parameter int DEPTH   = 16,
   parameter int NDIGITS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [4*DEPTH-1:0]         load_data,
   input  logic [$clog2(DEPTH+1)-1:0] load_len,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   output logic [7*NDIGITS-1:0]       hex_out
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int CW = $clog2(DEPTH+NDIGITS+1);
   localparam logic [6:0] BLANK = 7'h7F;

   typedef enum logic {IDLE, SCROLL} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0:    seg7 = 7'h40;
         4'h1:    seg7 = 7'h79;
         4'h2:    seg7 = 7'h24;
         4'h3:    seg7 = 7'h30;
         4'h4:    seg7 = 7'h19;
         4'h5:    seg7 = 7'h12;
         4'h6:    seg7 = 7'h02;
         4'h7:    seg7 = 7'h78;
         4'h8:    seg7 = 7'h00;
         4'h9:    seg7 = 7'h10;
         4'hA:    seg7 = 7'h08;
         4'hB:    seg7 = 7'h03;
         4'hC:    seg7 = 7'h46;
         4'hD:    seg7 = 7'h21;
         4'hE:    seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   state_t             state;
   logic               en_d;
   logic               tick;
   logic [4*DEPTH-1:0] msg;
   logic [LW-1:0]      len_q;
   logic [LW-1:0]      len_clamped;
   logic [CW-1:0]      len_ext;
   logic [CW-1:0]      idx;
   logic [3:0]         nib;
   logic [6:0]         next_digit;

   assign tick        = en & ~en_d;
   assign len_clamped = (load_len > LW'(DEPTH)) ? LW'(DEPTH) : load_len;
   assign len_ext     = CW'(len_q);

   always_comb begin
      nib = 4'h0;
      for (int k = 0; k < DEPTH; k++)
         if (idx == CW'(k)) nib = msg[4*k +: 4];
   end

   assign next_digit = (idx < len_ext) ? seg7(nib) : BLANK;

   // NOTE: en_d follows en even during reset, so a level held across reset is not an edge.
   always_ff @(posedge clk) en_d <= en;

   // NOTE: the message buffer is deliberately unreset; it is only read after an accept fills it.
   always_ff @(posedge clk)
      if (load_valid && load_ready) msg <= load_data;

   // idx doubles as the step count: one increment per tick from the accept onwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         load_ready <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         hex_out    <= {NDIGITS{BLANK}};
         idx        <= '0;
         len_q      <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            hex_out    <= {NDIGITS{BLANK}};
            idx        <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (load_valid && load_ready) begin
                     len_q <= len_clamped;
                     idx   <= '0;
                     if (len_clamped == '0) begin
                        done <= 1'b1;
                     end else begin
                        state      <= SCROLL;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                     end
                  end
               end
               SCROLL: begin
                  if (tick) begin
                     hex_out <= {hex_out[7*NDIGITS-8:0], next_digit};
`ifdef DISPLAY_SCROLL_LOOP_EN
                     idx <= (idx < len_ext) ? idx + CW'(1) : '0;
`else
                     idx <= idx + CW'(1);
                     if (idx + CW'(1) == len_ext + CW'(NDIGITS)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        done       <= 1'b1;
                     end
`endif
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_scroller.sv
// Scoreboard bench for display_scroller: the stimulus side predicts each cycle's outputs from
// the visible-window rule; a negedge monitor pops and compares. Honours DISPLAY_SCROLL_LOOP_EN.
module tb_display_scroller;

   localparam int DEPTH   = 16;
   localparam int NDIGITS = 4;
   localparam logic [27:0] ALL_BLANK = {4{7'h7F}};

   logic        clk;
   logic        reset;
   logic        en;
   logic        load_valid;
   logic        load_ready;
   logic [63:0] load_data;
   logic [4:0]  load_len;
   logic        abort;
   logic        busy;
   logic        done;
   logic [27:0] hex_out;

   display_scroller #(.DEPTH(DEPTH), .NDIGITS(NDIGITS)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .hex_out    (hex_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          edge_no;
      logic [27:0] hex;
      logic        busy;
      logic        ready;
      logic        done;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt = 0;
   int   checks   = 0;
   int   failures = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference model state: message, length, ticks seen since accept
   bit         m_scroll = 0;
   int         m_len    = 0;
   int         m_t      = 0;
   logic [3:0] m_msg [DEPTH];
   logic       m_prev_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h expected=%h", name, edge_cnt, act, exp);
      end
   endtask

   // After t ticks, digit d shows stream position t-1-d; the stream is the message then blanks
   // (or, when looping, the message plus one blank repeated).
   function automatic logic [27:0] window(input int t);
      logic [27:0] w;
      int p;
      w = ALL_BLANK;
      for (int dg = 0; dg < NDIGITS; dg++) begin
         p = t - 1 - dg;
         if (p >= 0) begin
`ifdef DISPLAY_SCROLL_LOOP_EN
            p = p % (m_len + 1);
`endif
            if (p < m_len) w[7*dg +: 7] = seg_tab[m_msg[p]];
         end
      end
      return w;
   endfunction

   task automatic drive(input logic rst, input logic e, input logic lv, input logic [63:0] d,
                        input logic [4:0] l, input logic ab);
      exp_t x;
      logic tk;
      reset      = rst;
      en         = e;
      load_valid = lv;
      load_data  = d;
      load_len   = l;
      abort      = ab;
      tk         = e & ~m_prev_en;
      m_prev_en  = e;
      x.done     = 1'b0;
      if (rst || ab) begin
         m_scroll = 0;
      end else if (!m_scroll) begin
         if (lv) begin
            m_len = (int'(l) > DEPTH) ? DEPTH : int'(l);
            for (int k = 0; k < DEPTH; k++) m_msg[k] = d[4*k +: 4];
            if (m_len == 0) x.done = 1'b1;
            else begin
               m_scroll = 1;
               m_t      = 0;
            end
         end
      end else if (tk) begin
         m_t++;
`ifndef DISPLAY_SCROLL_LOOP_EN
         if (m_t == m_len + NDIGITS) begin
            m_scroll = 0;
            x.done   = 1'b1;
         end
`endif
      end
      x.hex     = m_scroll ? window(m_t) : ALL_BLANK;
      x.busy    = m_scroll;
      x.ready   = !m_scroll;
      x.edge_no = edge_cnt + 1;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n, input logic e);
      repeat (n) drive(1'b0, e, 1'b0, 64'h0, 5'd0, 1'b0);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         drive(1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0);
         drive(1'b0, 1'b1, 1'b0, 64'h0, 5'd0, 1'b0);
      end
   endtask

   task automatic end_msg();
`ifdef DISPLAY_SCROLL_LOOP_EN
      drive(1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1);
`endif
      idle_cycles(2, 1'b0);
   endtask

   // monitor: compare every expectation whose edge has just passed
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
            x = sb.pop_front();
            check("hex_out", 32'(hex_out), 32'(x.hex));
            check("busy", 32'(busy), 32'(x.busy));
            check("load_ready", 32'(load_ready), 32'(x.ready));
            check("done", 32'(done), 32'(x.done));
         end
      end
   end

   initial begin
      logic [63:0] d;
      logic [4:0]  l;
      logic        e;
      logic        ab;
      logic        rst;

      reset = 1'b1; en = 1'b1; load_valid = 1'b0; load_data = '0; load_len = '0; abort = 1'b0;

      // reset with en held high, then keep en high
      repeat (3) drive(1'b1, 1'b1, 1'b0, 64'h0, 5'd0, 1'b0);
      idle_cycles(10, 1'b1);
      check("rst_hex", 32'(hex_out), 32'(ALL_BLANK));

      // len=2 message A,5
      drive(1'b0, 1'b0, 1'b1, 64'h5A, 5'd2, 1'b0);
      ticks(1);
      check("t1_digit0", 32'(hex_out[6:0]), 32'(7'h08));
      ticks(1);
      check("t2_hex", 32'(hex_out), 32'({7'h7F, 7'h7F, 7'h08, 7'h12}));
      ticks(4);
      end_msg();

      // len=0: done next cycle, display unchanged
      drive(1'b0, 1'b0, 1'b1, 64'h1234, 5'd0, 1'b0);
      idle_cycles(2, 1'b0);

      // load offers while scrolling are ignored
      drive(1'b0, 1'b0, 1'b1, 64'h0C7, 5'd3, 1'b0);
      ticks(1);
      repeat (3) drive(1'b0, 1'b0, 1'b1, 64'hFFFF_EEEE, 5'd5, 1'b0);
      ticks(6);
      end_msg();

      // abort after tick 3 of an 8-nibble message
      drive(1'b0, 1'b0, 1'b1, 64'h8765_4321, 5'd8, 1'b0);
      ticks(3);
      drive(1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1);
      idle_cycles(3, 1'b0);

      // overlong length clamps to DEPTH
      drive(1'b0, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, 5'd31, 1'b0);
      ticks(DEPTH + NDIGITS);
      end_msg();

`ifdef DISPLAY_SCROLL_LOOP_EN
      // single-nibble loop: F, blank, F, blank ...
      drive(1'b0, 1'b0, 1'b1, 64'hF, 5'd1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         ticks(1);
         check("loop_digit0", 32'(hex_out[6:0]), (i % 2 == 1) ? 32'h0E : 32'h7F);
      end
      end_msg();
`endif

      // randomized messages with ragged en, stray loads, aborts and one mid-scroll reset
      e = 1'b0;
      for (int m = 0; m < 60; m++) begin
         d = {$urandom, $urandom};
         l = 5'($urandom_range(0, 31));
         drive(1'b0, e, 1'b1, d, l, 1'($urandom_range(0, 15) == 0));
         for (int c = 0; c < 300 && m_scroll; c++) begin
            if ($urandom_range(0, 2) == 0) e = ~e;
            ab = 1'($urandom_range(0, 199) == 0);
`ifdef DISPLAY_SCROLL_LOOP_EN
            if (c >= 100) ab = 1'b1;
`endif
            rst = (m == 30 && c == 6);
            drive(rst, e, 1'($urandom_range(0, 3) == 0), {$urandom, $urandom},
                  5'($urandom_range(0, 31)), rst | ab);
         end
         if ($urandom_range(0, 9) == 0) drive(1'b0, e, 1'b0, 64'h0, 5'd0, 1'b1);
      end

      idle_cycles(3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
